// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_pkg
// Description : Shared types and constants for the control pipeline. Holds
//               the ID-stage control bundle layout and the EX operand
//               forwarding select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pipe_pkg;

    // Decoded control for one instruction as it leaves ID.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_t;

    // A bubble is an all-zero bundle: it writes nothing and touches no memory.
    localparam ctrl_t c_bubble = '0;

    // EX operand source selects.
    localparam logic [1:0] c_fwd_rf    = 2'b00;  // register file value
    localparam logic [1:0] c_fwd_exmem = 2'b10;  // result held in EX/MEM
    localparam logic [1:0] c_fwd_memwb = 2'b01;  // result held in MEM/WB

endpackage : ctrl_pipe_pkg
`default_nettype wire

// File: rtl/ctrl_pipe_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_hazard_detect
// Description : Purely combinational RAW hazard and forwarding decision.
//               Build option CTRL_PIPE_FWD_EN:
//                 defined   - forwarding selects driven; only a load in EX
//                             whose rd feeds the ID instruction stalls.
//                 undefined - selects tied to register file; any pending
//                             write in EX or MEM to an ID source stalls.
//               A destination of x0 never creates a dependency, and a match
//               against the WB stage never stalls (regfile writes first).
// Ports       : i_id_rs1/i_id_rs2     ID source registers
//               i_ex_rd, i_mem_rd     destination regs held in ID/EX, EX/MEM
//               i_mem_reg_write       EX/MEM RegWrite
//               (fwd)  i_ex_mem_read, i_ex_rs1/rs2, i_wb_reg_write, i_wb_rd
//               (nofwd) i_ex_reg_write
//               o_stall               hold PC/IF/ID, bubble into EX
//               o_fwd_a/o_fwd_b       EX operand selects
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe_hazard_detect
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
`ifdef CTRL_PIPE_FWD_EN
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rs1,
    input  logic [REG_AW-1:0] i_ex_rs2,
    input  logic              i_wb_reg_write,
    input  logic [REG_AW-1:0] i_wb_rd,
`else
    input  logic              i_ex_reg_write,
`endif
    output logic              o_stall,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b
);

    // A nonzero rd equal to rs implies rs is nonzero as well, so x0 sources
    // are excluded without a separate test.
    logic w_ex_hits_id;
    logic w_mem_hits_id;

    assign w_ex_hits_id  = (i_ex_rd  != '0) && ((i_ex_rd  == i_id_rs1) || (i_ex_rd  == i_id_rs2));
    assign w_mem_hits_id = (i_mem_rd != '0) && ((i_mem_rd == i_id_rs1) || (i_mem_rd == i_id_rs2));

`ifdef CTRL_PIPE_FWD_EN
    // Only a load cannot be forwarded in time: its data exists after MEM.
    assign o_stall = i_ex_mem_read && w_ex_hits_id;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        o_fwd_a = c_fwd_rf;
        o_fwd_b = c_fwd_rf;
        if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs1)) begin
            o_fwd_a = c_fwd_exmem;
        end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs1)) begin
            o_fwd_a = c_fwd_memwb;
        end
        if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs2)) begin
            o_fwd_b = c_fwd_exmem;
        end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs2)) begin
            o_fwd_b = c_fwd_memwb;
        end
    end
`else
    // Without bypass paths the consumer waits until the producer reaches WB.
    assign o_stall = (i_ex_reg_write && w_ex_hits_id) || (i_mem_reg_write && w_mem_hits_id);
    assign o_fwd_a = c_fwd_rf;
    assign o_fwd_b = c_fwd_rf;
`endif

endmodule : ctrl_pipe_hazard_detect
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Carries the decoded control bundle from ID through the
//               ID/EX, EX/MEM and MEM/WB registers, inserts bubbles on RAW
//               stalls or branch flushes, and counts stall cycles.
//               Build option CTRL_PIPE_FWD_EN enables operand forwarding
//               (rs1/rs2 tracked in ID/EX, only load-use stalls).
// Ports       : clk_i, rst_i (sync, active-high)
//               RegWrite_i..ALUSrc_i, rs1_i, rs2_i, rd_i   ID-stage bundle
//               flush_i                                    squash ID instr
//               ex_ALUOp_o, ex_ALUSrc_o                    EX controls
//               mem_MemRead_o, mem_MemWrite_o              MEM controls
//               wb_RegWrite_o, wb_MemtoReg_o, wb_rd_o      WB controls
//               stall_o                                    hold PC + IF/ID
//               fwd_a_o, fwd_b_o                           EX operand selects
//               stall_cnt_o                                stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    output logic [1:0]        ex_ALUOp_o,
    output logic              ex_ALUSrc_o,
    output logic              mem_MemRead_o,
    output logic              mem_MemWrite_o,
    output logic              wb_RegWrite_o,
    output logic              wb_MemtoReg_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    ctrl_t             w_id_ctrl;
    logic              w_stall;
    logic              w_bubble;

    // ID/EX
    ctrl_t             r_idex_ctrl;
    logic [REG_AW-1:0] r_idex_rd;
`ifdef CTRL_PIPE_FWD_EN
    logic [REG_AW-1:0] r_idex_rs1;
    logic [REG_AW-1:0] r_idex_rs2;
`endif

    // EX/MEM: only the fields still needed downstream
    logic              r_exmem_reg_write;
    logic              r_exmem_mem_to_reg;
    logic              r_exmem_mem_read;
    logic              r_exmem_mem_write;
    logic [REG_AW-1:0] r_exmem_rd;

    // MEM/WB
    logic              r_memwb_reg_write;
    logic              r_memwb_mem_to_reg;
    logic [REG_AW-1:0] r_memwb_rd;

    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_id_ctrl = '{reg_write:  RegWrite_i,
                         mem_to_reg: MemtoReg_i,
                         mem_read:   MemRead_i,
                         mem_write:  MemWrite_i,
                         alu_op:     ALUOp_i,
                         alu_src:    ALUSrc_i};

    // A stalled instruction stays in IF/ID and re-issues later; a flushed
    // one is dropped. Either way nothing valid enters EX this cycle.
    assign w_bubble = w_stall || flush_i;

    ctrl_pipe_hazard_detect #(
        .REG_AW          (REG_AW)
    ) u_hazard (
        .i_id_rs1        (rs1_i),
        .i_id_rs2        (rs2_i),
        .i_ex_rd         (r_idex_rd),
        .i_mem_rd        (r_exmem_rd),
        .i_mem_reg_write (r_exmem_reg_write),
`ifdef CTRL_PIPE_FWD_EN
        .i_ex_mem_read   (r_idex_ctrl.mem_read),
        .i_ex_rs1        (r_idex_rs1),
        .i_ex_rs2        (r_idex_rs2),
        .i_wb_reg_write  (r_memwb_reg_write),
        .i_wb_rd         (r_memwb_rd),
`else
        .i_ex_reg_write  (r_idex_ctrl.reg_write),
`endif
        .o_stall         (w_stall),
        .o_fwd_a         (fwd_a_o),
        .o_fwd_b         (fwd_b_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idex_ctrl        <= c_bubble;
            r_idex_rd          <= '0;
`ifdef CTRL_PIPE_FWD_EN
            r_idex_rs1         <= '0;
            r_idex_rs2         <= '0;
`endif
            r_exmem_reg_write  <= 1'b0;
            r_exmem_mem_to_reg <= 1'b0;
            r_exmem_mem_read   <= 1'b0;
            r_exmem_mem_write  <= 1'b0;
            r_exmem_rd         <= '0;
            r_memwb_reg_write  <= 1'b0;
            r_memwb_mem_to_reg <= 1'b0;
            r_memwb_rd         <= '0;
        end else begin
            r_memwb_reg_write  <= r_exmem_reg_write;
            r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
            r_memwb_rd         <= r_exmem_rd;

            r_exmem_reg_write  <= r_idex_ctrl.reg_write;
            r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
            r_exmem_mem_read   <= r_idex_ctrl.mem_read;
            r_exmem_mem_write  <= r_idex_ctrl.mem_write;
            r_exmem_rd         <= r_idex_rd;

            if (w_bubble) begin
                r_idex_ctrl    <= c_bubble;
                r_idex_rd      <= '0;
`ifdef CTRL_PIPE_FWD_EN
                r_idex_rs1     <= '0;
                r_idex_rs2     <= '0;
`endif
            end else begin
                r_idex_ctrl    <= w_id_ctrl;
                r_idex_rd      <= rd_i;
`ifdef CTRL_PIPE_FWD_EN
                r_idex_rs1     <= rs1_i;
                r_idex_rs2     <= rs2_i;
`endif
            end
        end
    end

    // Free-running wrap-around count of stalled cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ex_ALUOp_o     = r_idex_ctrl.alu_op;
    assign ex_ALUSrc_o    = r_idex_ctrl.alu_src;
    assign mem_MemRead_o  = r_exmem_mem_read;
    assign mem_MemWrite_o = r_exmem_mem_write;
    // Writes to x0 are architecturally discarded.
    assign wb_RegWrite_o  = r_memwb_reg_write && (r_memwb_rd != '0);
    assign wb_MemtoReg_o  = r_memwb_mem_to_reg;
    assign wb_rd_o        = r_memwb_rd;
    assign stall_o        = w_stall;
    assign stall_cnt_o    = r_stall_cnt;

endmodule : ctrl_pipe
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe
// Description : Self-checking bench for ctrl_pipe. A reference model keeps
//               the history of instructions accepted into EX and derives the
//               expected stage controls, stall, forwarding selects and stall
//               count from the pipeline rules. Directed scenarios first, then
//               randomized traffic with occasional flushes and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam int CNT_W  = 2;
    localparam int REG_AW = 5;
`ifdef CTRL_PIPE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, flush;
    logic [1:0]        ALUOp;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [1:0]        ex_ALUOp_o;
    logic              ex_ALUSrc_o, mem_MemRead_o, mem_MemWrite_o;
    logic              wb_RegWrite_o, wb_MemtoReg_o, stall_o;
    logic [REG_AW-1:0] wb_rd_o;
    logic [1:0]        fwd_a_o, fwd_b_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    always #5 clk = ~clk;

    ctrl_pipe #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .RegWrite_i     (RegWrite),
        .MemtoReg_i     (MemtoReg),
        .MemRead_i      (MemRead),
        .MemWrite_i     (MemWrite),
        .ALUOp_i        (ALUOp),
        .ALUSrc_i       (ALUSrc),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .rd_i           (rd),
        .flush_i        (flush),
        .ex_ALUOp_o     (ex_ALUOp_o),
        .ex_ALUSrc_o    (ex_ALUSrc_o),
        .mem_MemRead_o  (mem_MemRead_o),
        .mem_MemWrite_o (mem_MemWrite_o),
        .wb_RegWrite_o  (wb_RegWrite_o),
        .wb_MemtoReg_o  (wb_MemtoReg_o),
        .wb_rd_o        (wb_rd_o),
        .stall_o        (stall_o),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    typedef struct {
        bit       rw, mtr, mr, mw, src;
        bit [1:0] op;
        bit [4:0] rd, rs1, rs2;
    } instr_t;

    // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
    instr_t hist[$];
    int     stall_total;
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic instr_t mk(bit rw, bit mtr, bit mr, bit mw, bit [1:0] op, bit src,
                                  bit [4:0] d, bit [4:0] s1, bit [4:0] s2);
        instr_t b;
        b.rw = rw; b.mtr = mtr; b.mr = mr; b.mw = mw; b.op = op; b.src = src;
        b.rd = d; b.rs1 = s1; b.rs2 = s2;
        return b;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0);
    endfunction
    function automatic instr_t lw(bit [4:0] d, bit [4:0] s1);
        return mk(1, 1, 1, 0, 2'd0, 1, d, s1, 5'd0);
    endfunction
    function automatic instr_t alu(bit [4:0] d, bit [4:0] s1, bit [4:0] s2);
        return mk(1, 0, 0, 0, 2'd2, 0, d, s1, s2);
    endfunction
    function automatic instr_t sw(bit [4:0] s1, bit [4:0] s2);
        return mk(0, 0, 0, 1, 2'd0, 1, 5'd0, s1, s2);
    endfunction

    // True when producer b will write register r (x0 never counts).
    function automatic bit writes(instr_t b, bit [4:0] r);
        return b.rw && (b.rd != 0) && (r != 0) && (b.rd == r);
    endfunction

    function automatic bit exp_stall(instr_t id);
        if (FWD_EN) begin
            return hist[0].mr && (writes(hist[0], id.rs1) || writes(hist[0], id.rs2)
                   || (hist[0].rd != 0 && (hist[0].rd == id.rs1 || hist[0].rd == id.rs2)));
        end
        for (int i = 0; i < 2; i++) begin
            if (writes(hist[i], id.rs1) || writes(hist[i], id.rs2)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit [1:0] exp_fwd(bit [4:0] rs);
        if (!FWD_EN)              return 2'b00;
        if (writes(hist[1], rs))  return 2'b10;
        if (writes(hist[2], rs))  return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(instr_t b, bit fl);
        RegWrite = b.rw; MemtoReg = b.mtr; MemRead = b.mr; MemWrite = b.mw;
        ALUOp = b.op; ALUSrc = b.src; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
        flush = fl;
    endtask

    // Present b in ID for one cycle, compare every output, advance the model.
    task automatic step(instr_t b, bit fl, output bit st);
        instr_t dropped;
        drive(b, fl);
        #2;
        st = exp_stall(b);
        chk("ex_ALUOp",     ex_ALUOp_o,     hist[0].op);
        chk("ex_ALUSrc",    ex_ALUSrc_o,    hist[0].src);
        chk("mem_MemRead",  mem_MemRead_o,  hist[1].mr);
        chk("mem_MemWrite", mem_MemWrite_o, hist[1].mw);
        chk("wb_RegWrite",  wb_RegWrite_o,  hist[2].rw && hist[2].rd != 0);
        chk("wb_MemtoReg",  wb_MemtoReg_o,  hist[2].mtr);
        chk("wb_rd",        wb_rd_o,        hist[2].rd);
        chk("stall",        stall_o,        st);
        chk("fwd_a",        fwd_a_o,        exp_fwd(hist[0].rs1));
        chk("fwd_b",        fwd_b_o,        exp_fwd(hist[0].rs2));
        chk("stall_cnt",    stall_cnt_o,    stall_total % (1 << CNT_W));
        @(posedge clk);
        #1;
        hist.push_front((st || fl) ? nop() : b);
        dropped = hist.pop_back();
        if (st) stall_total++;
    endtask

    // Keep presenting b until it is accepted (a stalled ID instruction re-issues).
    task automatic issue(instr_t b, bit fl = 1'b0);
        bit st;
        int n = 0;
        do begin
            step(b, fl, st);
            n++;
        end while (st && !fl && n < 6);
    endtask

    task automatic do_reset();
        drive(alu(5'd9, 5'd1, 5'd2), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
        repeat (3) hist.push_back(nop());
        stall_total = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit st;
        rst = 1'b1;

        // Reset with an R-type bundle sitting on the inputs.
        do_reset();
        chk("rst_ex_ALUOp",    ex_ALUOp_o,     0);
        chk("rst_ex_ALUSrc",   ex_ALUSrc_o,    0);
        chk("rst_mem_MemRead", mem_MemRead_o,  0);
        chk("rst_mem_MemWrite",mem_MemWrite_o, 0);
        chk("rst_wb_RegWrite", wb_RegWrite_o,  0);
        chk("rst_wb_rd",       wb_rd_o,        0);
        chk("rst_stall",       stall_o,        0);
        chk("rst_fwd_a",       fwd_a_o,        0);
        chk("rst_stall_cnt",   stall_cnt_o,    0);

        // Latency of a load bundle through EX, MEM, WB.
        issue(lw(5'd5, 5'd1));
        chk("lat_ex_ALUSrc", ex_ALUSrc_o, 1);
        issue(nop());
        chk("lat_mem_MemRead", mem_MemRead_o, 1);
        issue(nop());
        chk("lat_wb_RegWrite", wb_RegWrite_o, 1);
        chk("lat_wb_MemtoReg", wb_MemtoReg_o, 1);
        chk("lat_wb_rd",       wb_rd_o,       5);

        // Load-use; then an x0 source against an empty EX.
        do_reset();
        issue(lw(5'd5, 5'd0));
        issue(alu(5'd6, 5'd5, 5'd0));
        chk("lu_stall_cnt", stall_cnt_o, FWD_EN ? 1 : 2);
        chk("lu_fwd_a",     fwd_a_o,     FWD_EN ? 2'b01 : 2'b00);
        issue(nop());
        issue(alu(5'd7, 5'd0, 5'd0));
        chk("x0_stall_cnt", stall_cnt_o, FWD_EN ? 1 : 2);

        // Back-to-back ALU dependency.
        do_reset();
        issue(alu(5'd3, 5'd1, 5'd2));
        issue(alu(5'd4, 5'd3, 5'd3));
        chk("b2b_fwd_a",     fwd_a_o,     FWD_EN ? 2'b10 : 2'b00);
        chk("b2b_fwd_b",     fwd_b_o,     FWD_EN ? 2'b10 : 2'b00);
        chk("b2b_stall_cnt", stall_cnt_o, FWD_EN ? 0 : 2);

        // One nop between producer and consumer.
        do_reset();
        issue(alu(5'd3, 5'd1, 5'd2));
        issue(nop());
        issue(alu(5'd4, 5'd3, 5'd3));
        chk("gap_fwd_a",     fwd_a_o,     FWD_EN ? 2'b01 : 2'b00);
        chk("gap_stall_cnt", stall_cnt_o, FWD_EN ? 0 : 1);

        // x3 written in both MEM and WB: the younger one wins.
        do_reset();
        issue(alu(5'd3, 5'd1, 5'd2));
        issue(alu(5'd3, 5'd1, 5'd1));
        issue(alu(5'd4, 5'd3, 5'd3));
        chk("dbl_fwd_a", fwd_a_o, FWD_EN ? 2'b10 : 2'b00);

        // Flushed store never reaches MEM.
        do_reset();
        issue(sw(5'd1, 5'd2), 1'b1);
        issue(nop());
        chk("flush_mem_MemWrite", mem_MemWrite_o, 0);

        // Flush together with a load-use stall still counts the stall.
        do_reset();
        issue(lw(5'd5, 5'd0));
        step(alu(5'd6, 5'd5, 5'd0), 1'b1, st);
        chk("fs_stall_cnt", stall_cnt_o, 1);
        issue(nop());
        issue(nop());

        // Counter wrap with a 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(lw(5'd5, 5'd0));
            issue(alu(5'd6, 5'd5, 5'd0));
            chk("wrap_cnt", stall_cnt_o, (FWD_EN ? (i + 1) : 2 * (i + 1)) % 4);
        end

        // Randomized traffic on a small register set to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                instr_t b;
                b = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       2'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                step(b, ($urandom_range(0, 9) == 0), st);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ctrl_pipe
`default_nettype wire
